// File: rtl/hazard_fwd_unit.sv
// Load-use hazard detection and forwarding-select generation for an in-order pipeline.
// Tracks DEPTH in-flight producers and resolves each ID source to the youngest matching writer.
module hazard_fwd_unit #(
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned LOAD_LAT = 1,
  localparam int unsigned SW      = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic                      id_wr,
  input  logic                      id_load,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs,
  input  logic [NUM_SRC-1:0]        id_rs_used,
  input  logic                      flush,
  output logic                      stall,
  output logic [NUM_SRC*SW-1:0]     fwd_sel,
  output logic [15:0]               stall_cnt
);

  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [DEPTH-1:0]             wr_q, wr_d;
  logic [DEPTH-1:0]             load_q, load_d;
  logic [DEPTH-1:0][REG_AW-1:0] rd_q, rd_d;
  logic [15:0]                  stall_cnt_q, stall_cnt_d;
  logic [NUM_SRC-1:0]           hazard;

  logic [REG_AW-1:0] rs;
  logic              hit;
  logic              hit_load;
  int                win;

  // Scan oldest to youngest so the lowest matching slot index is the one kept.
  always_comb begin : match_resolve
    hazard   = '0;
    fwd_sel  = '0;
    rs       = '0;
    hit      = 1'b0;
    hit_load = 1'b0;
    win      = 0;
    for (int s = 0; s < int'(NUM_SRC); s++) begin
      rs       = id_rs[s*REG_AW +: REG_AW];
      hit      = 1'b0;
      hit_load = 1'b0;
      win      = 0;
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
        if (id_rs_used[s] && (rs != '0) && valid_q[i] && wr_q[i] && (rd_q[i] == rs)) begin
          hit      = 1'b1;
          hit_load = load_q[i];
          win      = i;
        end
      end
      hazard[s] = hit && hit_load && (win < int'(LOAD_LAT));
      if (hit && !hazard[s]) begin
        fwd_sel[s*SW +: SW] = SW'(win + 1);
      end
    end
  end

  assign stall     = id_valid & ~flush & (|hazard);
  assign stall_cnt = stall_cnt_q;

  // Producer tracking shifts every cycle; stalled or flushed ID injects a bubble.
  always_comb begin : slot_shift
    valid_d = '0;
    wr_d    = '0;
    load_d  = '0;
    rd_d    = '0;
    for (int i = 1; i < int'(DEPTH); i++) begin
      valid_d[i] = valid_q[i-1];
      wr_d[i]    = wr_q[i-1];
      load_d[i]  = load_q[i-1];
      rd_d[i]    = rd_q[i-1];
    end
    valid_d[0] = id_valid & ~stall & ~flush;
    wr_d[0]    = id_wr;
    load_d[0]  = id_load;
    rd_d[0]    = id_rd;
    stall_cnt_d = (stall && (stall_cnt_q != 16'hFFFF)) ? stall_cnt_q + 16'd1 : stall_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= '0;
      wr_q        <= '0;
      load_q      <= '0;
      rd_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      wr_q        <= wr_d;
      load_q      <= load_d;
      rd_q        <= rd_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Scoreboard bench for hazard_fwd_unit: default, LOAD_LAT=0, wide (3/4/2) and saturation instances.
`timescale 1ns/1ps
module tb_hazard_fwd_unit;

  localparam int unsigned AW = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic            id_valid, id_wr, id_load, flush;
  logic [AW-1:0]   id_rd;
  logic [2*AW-1:0] id_rs;
  logic [1:0]      id_rs_used;
  logic            stall;
  logic [3:0]      fwd_sel;
  logic [15:0]     stall_cnt;

  logic            d0_stall;
  logic [3:0]      d0_fwd;
  logic [15:0]     d0_cnt;

  logic            dp_valid, dp_wr, dp_load, dp_flush;
  logic [AW-1:0]   dp_rd;
  logic [3*AW-1:0] dp_rs;
  logic [2:0]      dp_used;
  logic            dp_stall;
  logic [8:0]      dp_fwd;
  logic [15:0]     dp_cnt;

  logic            ds_valid;
  logic            ds_stall;
  logic [3:0]      ds_fwd;
  logic [15:0]     ds_cnt;

  hazard_fwd_unit dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_wr(id_wr), .id_load(id_load),
    .id_rd(id_rd), .id_rs(id_rs), .id_rs_used(id_rs_used), .flush(flush),
    .stall(stall), .fwd_sel(fwd_sel), .stall_cnt(stall_cnt)
  );

  hazard_fwd_unit #(.LOAD_LAT(0)) dut_ll0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_wr(id_wr), .id_load(id_load),
    .id_rd(id_rd), .id_rs(id_rs), .id_rs_used(id_rs_used), .flush(flush),
    .stall(d0_stall), .fwd_sel(d0_fwd), .stall_cnt(d0_cnt)
  );

  hazard_fwd_unit #(.NUM_SRC(3), .DEPTH(4), .LOAD_LAT(2)) dut_wide (
    .clk(clk), .rst_n(rst_n), .id_valid(dp_valid), .id_wr(dp_wr), .id_load(dp_load),
    .id_rd(dp_rd), .id_rs(dp_rs), .id_rs_used(dp_used), .flush(dp_flush),
    .stall(dp_stall), .fwd_sel(dp_fwd), .stall_cnt(dp_cnt)
  );

  // Self-dependent load held in ID: stalls 8 of every 9 cycles.
  hazard_fwd_unit #(.NUM_SRC(1), .DEPTH(8), .LOAD_LAT(8)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(ds_valid), .id_wr(1'b1), .id_load(1'b1),
    .id_rd(5'd7), .id_rs(5'd7), .id_rs_used(1'b1), .flush(1'b0),
    .stall(ds_stall), .fwd_sel(ds_fwd), .stall_cnt(ds_cnt)
  );

  typedef struct packed {
    logic          v, wr, ld;
    logic [AW-1:0] rd, rs0, rs1;
    logic [1:0]    used;
    logic          fl, xs;
    logic [1:0]    xf0, xf1;
  } row_t;

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [15:0] exp_cnt      = '0;
  logic [20:0] sb [$];
  logic [25:0] sbp [$];

  function automatic row_t mk(int v, int wr, int ld, int rd, int rs0, int rs1, int used,
                              int fl, int xs, int xf0, int xf1);
    row_t r;
    r.v = 1'(v);  r.wr = 1'(wr);  r.ld = 1'(ld);
    r.rd = AW'(rd);  r.rs0 = AW'(rs0);  r.rs1 = AW'(rs1);
    r.used = 2'(used);  r.fl = 1'(fl);  r.xs = 1'(xs);
    r.xf0 = 2'(xf0);  r.xf1 = 2'(xf1);
    return r;
  endfunction

  // Drive one ID instruction and record its expected outputs.
  task automatic drv(input row_t r);
    @(posedge clk); #1;
    id_valid = r.v;  id_wr = r.wr;  id_load = r.ld;  id_rd = r.rd;
    id_rs = {r.rs1, r.rs0};  id_rs_used = r.used;  flush = r.fl;
    sb.push_back({exp_cnt, r.xs, r.xf1, r.xf0});
    if (r.xs) exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    id_valid = 1'b1; id_wr = 1'b1; id_load = 1'b1; id_rd = 5'd3;
    id_rs = {5'd0, 5'd3}; id_rs_used = 2'b01; flush = 1'b0;
    dp_valid = 1'b0; dp_wr = 1'b0; dp_load = 1'b0; dp_flush = 1'b0;
    dp_rd = '0; dp_rs = '0; dp_used = '0; ds_valid = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall got %b want 0", stall); end
    tests_run++;
    if (fwd_sel !== 4'h0) begin tests_failed++; $display("FAIL reset_fwd got %h want 0", fwd_sel); end
    tests_run++;
    if (stall_cnt !== 16'd0) begin tests_failed++; $display("FAIL reset_cnt got %0d want 0", stall_cnt); end
    rst_n = 1'b1;
    #1;
    tests_run++;
    if ({stall, fwd_sel} !== 5'b0) begin
      tests_failed++; $display("FAIL post_reset got stall=%b fwd=%h want 0/0", stall, fwd_sel);
    end
    id_valid = 1'b0; id_wr = 1'b0; id_load = 1'b0; id_rs_used = 2'b00;
    exp_cnt = '0;
  endtask

  task automatic test_alu_fwd();
    row_t rows[$];
    logic [20:0] e;
    rows.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0));
    rows.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0));
    rows.push_back(mk(1,1,0,5,0,0,0,0, 0,0,0));
    rows.push_back(mk(1,0,0,0,5,0,1,0, 0,1,0));
    rows.push_back(mk(1,0,0,0,5,0,1,0, 0,2,0));
    rows.push_back(mk(1,1,0,6,0,0,0,0, 0,0,0));
    rows.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0));
    rows.push_back(mk(1,0,0,0,0,6,2,0, 0,0,2));
    rows.push_back(mk(1,1,0,6,0,0,0,0, 0,0,0));
    rows.push_back(mk(1,0,0,0,6,6,0,0, 0,0,0));
    foreach (rows[k]) begin
      drv(rows[k]);
      @(negedge clk);
      e = sb.pop_front();
      tests_run++;
      if ({stall_cnt, stall, fwd_sel} !== e) begin
        tests_failed++;
        $display("FAIL alu_fwd[%0d] got cnt=%0d stall=%b fwd=%h want cnt=%0d stall=%b fwd=%h",
                 k, stall_cnt, stall, fwd_sel, e[20:5], e[4], e[3:0]);
      end
    end
  endtask

  task automatic test_load_use();
    row_t rows[$];
    logic [20:0] e;
    rows.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0));
    rows.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0));
    rows.push_back(mk(1,1,1,7,0,0,0,0, 0,0,0));
    rows.push_back(mk(1,0,0,0,0,7,2,0, 1,0,0));
    rows.push_back(mk(1,0,0,0,0,7,2,0, 0,0,2));
    rows.push_back(mk(1,1,1,8,0,0,0,0, 0,0,0));
    rows.push_back(mk(1,1,0,9,0,0,0,0, 0,0,0));
    rows.push_back(mk(1,0,0,0,8,9,3,0, 0,2,1));
    rows.push_back(mk(1,1,1,10,0,0,0,0, 0,0,0));
    rows.push_back(mk(1,0,0,0,10,10,3,0, 1,0,0));
    rows.push_back(mk(1,0,0,0,10,10,3,0, 0,2,2));
    foreach (rows[k]) begin
      drv(rows[k]);
      @(negedge clk);
      e = sb.pop_front();
      tests_run++;
      if ({stall_cnt, stall, fwd_sel} !== e) begin
        tests_failed++;
        $display("FAIL load_use[%0d] got cnt=%0d stall=%b fwd=%h want cnt=%0d stall=%b fwd=%h",
                 k, stall_cnt, stall, fwd_sel, e[20:5], e[4], e[3:0]);
      end
      if (k == 3) begin
        tests_run++;
        if ({d0_stall, d0_fwd} !== 5'b0_0100) begin
          tests_failed++;
          $display("FAIL load_lat0 got stall=%b fwd=%h want stall=0 fwd=4", d0_stall, d0_fwd);
        end
      end
    end
  endtask

  task automatic test_priority();
    row_t rows[$];
    logic [20:0] e;
    rows.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0));
    rows.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0));
    rows.push_back(mk(1,1,0,3,0,0,0,0, 0,0,0));
    rows.push_back(mk(1,1,0,3,0,0,0,0, 0,0,0));
    rows.push_back(mk(1,0,0,0,3,3,3,0, 0,1,1));
    rows.push_back(mk(1,1,0,0,0,0,0,0, 0,0,0));
    rows.push_back(mk(1,0,0,0,0,0,1,0, 0,0,0));
    rows.push_back(mk(1,1,1,0,0,0,0,0, 0,0,0));
    rows.push_back(mk(1,0,0,0,0,0,3,0, 0,0,0));
    rows.push_back(mk(1,1,1,4,0,0,0,0, 0,0,0));
    rows.push_back(mk(1,1,0,4,0,0,0,0, 0,0,0));
    rows.push_back(mk(1,0,0,0,4,0,1,0, 0,1,0));
    foreach (rows[k]) begin
      drv(rows[k]);
      @(negedge clk);
      e = sb.pop_front();
      tests_run++;
      if ({stall_cnt, stall, fwd_sel} !== e) begin
        tests_failed++;
        $display("FAIL priority[%0d] got cnt=%0d stall=%b fwd=%h want cnt=%0d stall=%b fwd=%h",
                 k, stall_cnt, stall, fwd_sel, e[20:5], e[4], e[3:0]);
      end
    end
  endtask

  task automatic test_flush();
    row_t rows[$];
    logic [20:0] e;
    rows.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0));
    rows.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0));
    rows.push_back(mk(1,1,1,7,0,0,0,0, 0,0,0));
    rows.push_back(mk(1,1,0,9,7,0,1,1, 0,0,0));
    rows.push_back(mk(1,0,0,0,7,9,3,0, 0,2,0));
    rows.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0));
    foreach (rows[k]) begin
      drv(rows[k]);
      @(negedge clk);
      e = sb.pop_front();
      tests_run++;
      if ({stall_cnt, stall, fwd_sel} !== e) begin
        tests_failed++;
        $display("FAIL flush[%0d] got cnt=%0d stall=%b fwd=%h want cnt=%0d stall=%b fwd=%h",
                 k, stall_cnt, stall, fwd_sel, e[20:5], e[4], e[3:0]);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    row_t rows[$];
    logic [20:0] e;
    rows.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0));
    rows.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0));
    rows.push_back(mk(1,1,1,7,0,0,0,0, 0,0,0));
    rows.push_back(mk(1,0,0,0,0,7,2,0, 1,0,0));
    rows.push_back(mk(1,0,0,0,0,7,2,0, 0,0,0));
    rows.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0));
    foreach (rows[k]) begin
      drv(rows[k]);
      @(negedge clk);
      e = sb.pop_front();
      tests_run++;
      if ({stall_cnt, stall, fwd_sel} !== e) begin
        tests_failed++;
        $display("FAIL rst_mid[%0d] got cnt=%0d stall=%b fwd=%h want cnt=%0d stall=%b fwd=%h",
                 k, stall_cnt, stall, fwd_sel, e[20:5], e[4], e[3:0]);
      end
      if (k == 3) begin
        #1 rst_n = 1'b0;
        #1;
        tests_run++;
        if (stall !== 1'b0) begin tests_failed++; $display("FAIL rst_async_stall got %b want 0", stall); end
        tests_run++;
        if (stall_cnt !== 16'd0) begin tests_failed++; $display("FAIL rst_async_cnt got %0d want 0", stall_cnt); end
        exp_cnt = '0;
        #1 rst_n = 1'b1;
      end
    end
  endtask

  task automatic test_params();
    int tbl [7][11];
    logic [25:0] e;
    // v wr ld rd rs0 rs2 used | stall f0 f2 cnt
    tbl = '{'{0,0,0,0, 0,0,0, 0,0,0,0},
            '{1,1,0,8, 0,0,0, 0,0,0,0},
            '{1,1,1,7, 0,0,0, 0,0,0,0},
            '{1,0,0,0, 8,7,5, 1,2,0,0},
            '{1,0,0,0, 8,7,5, 1,3,0,1},
            '{1,0,0,0, 8,7,5, 0,4,3,2},
            '{0,0,0,0, 0,0,0, 0,0,0,2}};
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      dp_valid = 1'(tbl[k][0]); dp_wr = 1'(tbl[k][1]); dp_load = 1'(tbl[k][2]);
      dp_rd = AW'(tbl[k][3]);
      dp_rs = {AW'(tbl[k][5]), AW'(0), AW'(tbl[k][4])};
      dp_used = 3'(tbl[k][6]); dp_flush = 1'b0;
      sbp.push_back({16'(tbl[k][10]), 1'(tbl[k][7]), 3'(tbl[k][9]), 3'd0, 3'(tbl[k][8])});
      @(negedge clk);
      e = sbp.pop_front();
      tests_run++;
      if ({dp_cnt, dp_stall, dp_fwd} !== e) begin
        tests_failed++;
        $display("FAIL params[%0d] got cnt=%0d stall=%b fwd=%h want cnt=%0d stall=%b fwd=%h",
                 k, dp_cnt, dp_stall, dp_fwd, e[25:10], e[9], e[8:0]);
      end
    end
  endtask

  task automatic test_stall_cnt_sat();
    int          m;
    bit          bad;
    logic [15:0] want;
    m = 0;
    bad = 1'b0;
    @(posedge clk); #1;
    ds_valid = 1'b1;
    for (int c = 0; c < 80000 && m < 65540; c++) begin
      @(negedge clk);
      want = (m > 65535) ? 16'hFFFF : 16'(m);
      if (ds_cnt !== want) bad = 1'b1;
      if (ds_stall) m++;
    end
    tests_run++;
    if (m < 65540) begin tests_failed++; $display("FAIL sat_budget got %0d stalls want 65540", m); end
    tests_run++;
    if (bad) begin tests_failed++; $display("FAIL sat_track got diverging count want model count"); end
    @(negedge clk);
    tests_run++;
    if (ds_cnt !== 16'hFFFF) begin tests_failed++; $display("FAIL sat_hold got %h want ffff", ds_cnt); end
    ds_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_priority();
    test_flush();
    test_reset_mid_stall();
    test_params();
    test_stall_cnt_sat();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_unit.md
HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
REQ-001 SHALL have parameter NUM_SRC, default 2: number of source-register read ports checked per cycle.
REQ-002 SHALL have parameter DEPTH, default 2: number of in-flight producer slots tracked ahead of the consumer.
REQ-003 SHALL have parameter REG_AW, default 5: register address width.
REQ-004 SHALL have parameter LOAD_LAT, default 1: minimum slot index from which load data is forwardable; legal range 0..DEPTH.
REQ-005 SHALL define SW = clog2(DEPTH+1) as the forwarding-select field width.
REQ-006 SHALL have port clk, input, 1, rising-edge clock.
REQ-007 SHALL have port rst_n, input, 1; one clock, reset asynchronous and active-low.
REQ-008 SHALL have port id_valid, input, 1: ID-stage instruction present.
REQ-009 SHALL have port id_wr, input, 1: ID instruction writes a register.
REQ-010 SHALL have port id_load, input, 1: ID instruction is a load.
REQ-011 SHALL have port id_rd, input, REG_AW: ID destination register.
REQ-012 SHALL have port id_rs, input, NUM_SRC*REG_AW: source registers, port s at bits [s*REG_AW +: REG_AW].
REQ-013 SHALL have port id_rs_used, input, NUM_SRC: per-source read-enable.
REQ-014 SHALL have port flush, input, 1: kill the ID instruction this cycle.
REQ-015 SHALL have port stall, output, 1: hold IF/ID and insert a bubble.
REQ-016 SHALL have port fwd_sel, output, NUM_SRC*SW: per-source select; 0 = register file, k = slot k-1.
REQ-017 SHALL have port stall_cnt, output, 16: count of stall cycles.

Function
REQ-018 SHALL hold a DEPTH-entry shift register of {valid, wr, load, rd}; slot 0 is the youngest producer ahead of ID.
REQ-019 SHALL, on every rising edge, shift slot i into slot i+1 and discard slot DEPTH-1.
REQ-020 SHALL load slot 0 with {id_valid, id_wr, id_load, id_rd} when id_valid=1, stall=0 and flush=0, and with an invalid bubble otherwise.
REQ-021 SHALL treat source s as a match against slot i when id_rs_used[s]=1, rs_s!=0, slot.valid=1, slot.wr=1 and slot.rd==rs_s.
REQ-022 SHALL resolve multiple matches to the lowest slot index (youngest producer wins).
REQ-023 SHALL raise a hazard on source s when the winning slot has load=1 and index < LOAD_LAT.
REQ-024 SHALL drive fwd_sel[s] = winning index+1 when matched without hazard, and 0 when unmatched or hazarded; purely combinational, zero latency.
REQ-025 SHALL drive stall = id_valid & ~flush & (OR of all source hazards).
REQ-026 SHALL give flush priority over stall: flush=1 forces stall=0 and a bubble into slot 0.
REQ-027 SHALL clear the hazard once the load advances to slot >= LOAD_LAT; with defaults, a load-use pair stalls exactly 1 cycle and then forwards with fwd_sel=2.
REQ-028 SHALL make LOAD_LAT=0 disable stalling entirely.
REQ-029 SHALL increment stall_cnt on each edge where stall=1, saturating at 16'hFFFF.
REQ-030 SHALL make register 0 never produce a match or a stall.
REQ-031 SHALL, with defaults, reproduce the encoding of the classic two-stage forward unit: fwd_sel 1 = EX/MEM, 2 = MEM/WB.

Reset
REQ-032 SHALL, while rst_n=0, asynchronously clear all slot valid bits and stall_cnt to 0.
REQ-033 SHALL produce stall=0 and fwd_sel=0 for all sources immediately after reset.
REQ-034 SHALL discard in-flight tracking when rst_n is asserted mid-stall, without waiting for a clock edge.

Verification
REQ-035 SHALL cover ALU forwarding: issue wr x5; next cycle rs1=x5 -> fwd_sel[0]=1, stall=0; one cycle later (bubble between) -> fwd_sel[0]=2.
REQ-036 SHALL cover load-use: load x7, then rs2=x7 -> stall=1 for 1 cycle, stall_cnt=1, then fwd_sel[1]=2 and stall=0.
REQ-037 SHALL cover priority: two consecutive writes to x3, then rs1=rs2=x3 -> both fwd_sel=1; source x0 with a writer of x0 -> fwd_sel=0.
REQ-038 SHALL cover flush: load x7, then rs1=x7 with flush=1 -> stall=0 and slot 0 receives a bubble; the next ID instruction is unaffected by the killed one.
REQ-039 SHALL cover reset: assert rst_n=0 during a stall -> stall drops without a clock edge and stall_cnt=0; force stall_cnt to 16'hFFFF, stall again -> value holds at 16'hFFFF.
REQ-040 SHALL cover parameters: NUM_SRC=3, DEPTH=4, LOAD_LAT=2 -> load-use stalls 2 cycles, then fwd_sel=3.
